// File: rtl/ifq_if.sv
// Instruction fetch queue bus: fetch-side push handshake, decode-side pop
// handshake, flush request and occupancy count.
//   master : the fetch/decode environment driving the queue
//   slave  : the queue itself (ifq)
//   in_valid/in_code/in_pcc/in_ready    push side
//   out_valid/out_code/out_pcc/out_ready pop side (first-word-fall-through)
//   flush                                discard every entry
//   count                                number of valid entries, CW bits
interface ifq_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_code;
  logic [31:0]   in_pcc;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_code;
  logic [31:0]   out_pcc;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_code, in_pcc, out_ready, flush,
    input  in_ready, out_valid, out_code, out_pcc, count
  );

  modport slave (
    input  in_valid, in_code, in_pcc, out_ready, flush,
    output in_ready, out_valid, out_code, out_pcc, count
  );
endinterface

// File: rtl/ifq.sv
// Instruction fetch queue: DEPTH-entry FIFO (DEPTH = 2, 4 or 8) between the
// fetch and decode stages, holding {instruction word, link address} pairs.
// First-word-fall-through; a push is visible one cycle later, never bypassed.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high; priority over flush, push and pop
//   bus    ifq_if.slave (push/pop handshakes, flush, count)
// Optional feature: define IFQ_STALL_CNT_EN to add output stall_cnt[15:0],
// a saturating count of edges where the head is valid but not consumed.
module ifq #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  ifq_if.slave        bus
`ifdef IFQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  // Entry storage is not reset; empty-state outputs are masked to zero.
  logic [31:0]   code_q [DEPTH];
  logic [31:0]   pcc_q  [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          out_valid, in_ready;

  // Handshake status depends on registered state only.
  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < DepthC);

  always_comb begin
    push    = bus.in_valid && in_ready && !bus.flush;
    pop     = out_valid && bus.out_ready && !bus.flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      code_q[tail_q] <= bus.in_code;
      pcc_q[tail_q]  <= bus.in_pcc;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_code  = out_valid ? code_q[head_q] : '0;
  assign bus.out_pcc   = out_valid ? pcc_q[head_q]  : '0;
  assign bus.count     = count_q;

`ifdef IFQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready && !bus.flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the fetch queue.
module tb_ifq;
  localparam int unsigned DEPTH = 2;
  localparam int DepthI = int'(DEPTH);

  logic clk = 1'b0;
  logic reset;

  ifq_if #(.DEPTH(DEPTH)) bus ();

`ifdef IFQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ifq #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave)
`ifdef IFQ_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a plain queue of {code, pcc} words.
  logic [63:0] mq[$];
  int          m_stall = 0;
  bit          synced  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [31:0] code,
                       input logic [31:0] pcc, input logic ordy, input logic fl);
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_code   = code;
    bus.in_pcc    = pcc;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    head = (mq.size() != 0) ? mq[0] : 64'd0;
    check("count",     64'(bus.count),     64'(mq.size()));
    check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    check("in_ready",  64'(bus.in_ready),  64'(mq.size() < DepthI));
    check("out_code",  64'(bus.out_code),  64'(head[63:32]));
    check("out_pcc",   64'(bus.out_pcc),   64'(head[31:0]));
`ifdef IFQ_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // Check the current outputs, advance the model by one edge, then clock.
  task automatic cycle();
    bit do_push, do_pop, stall, synced_n;
    if (synced) check_outputs();
    synced_n = synced;
    do_push  = bus.in_valid && (mq.size() < DepthI);
    do_pop   = bus.out_ready && (mq.size() != 0);
    stall    = (mq.size() != 0) && !bus.out_ready && !bus.flush;
    if (reset) begin
      mq.delete();
      m_stall  = 0;
      synced_n = 1'b1;
    end else begin
      if (stall && m_stall < 16'hFFFF) m_stall++;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back({bus.in_code, bus.in_pcc});
      end
    end
    @(posedge clk);
    #1;
    synced = synced_n;
  endtask

  initial begin
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b0);

    // Reset held two cycles with in_valid high.
    cycle();
    cycle();
    check("rst_count",    64'(bus.count),     64'd0);
    check("rst_in_ready", 64'(bus.in_ready),  64'd1);
    check("rst_out_code", 64'(bus.out_code),  64'd0);

    // Fill; a third push while full is ignored.
    drive(1'b0, 1'b1, 32'h2008_0001, 32'h0000_3008, 1'b0, 1'b0);
    cycle();
    check("fwft_head", 64'(bus.out_code), 64'h2008_0001);
    drive(1'b0, 1'b1, 32'h2009_0002, 32'h0000_300C, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 32'h1000_0003, 32'h0000_3010, 1'b0, 1'b0);
    check("fill_count",    64'(bus.count),    64'd2);
    check("fill_in_ready", 64'(bus.in_ready), 64'd0);
    check("fill_head",     64'(bus.out_code), 64'h2008_0001);
    cycle();
    check("full_no_ovw",   64'(bus.out_code), 64'h2008_0001);

    // Full with pop and push offered: only the pop happens.
    drive(1'b0, 1'b1, 32'h1000_0004, 32'h0000_3014, 1'b1, 1'b0);
    cycle();
    check("full_pp_count", 64'(bus.count),    64'd1);
    check("full_pp_head",  64'(bus.out_code), 64'h2009_0002);

    // Simultaneous push and pop at count=1 for six cycles; pointers wrap.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 32'h4000_0000 + 32'(i), 32'h0000_5000 + 32'(4 * i), 1'b1, 1'b0);
      cycle();
      check("wrap_count", 64'(bus.count),    64'd1);
      check("wrap_head",  64'(bus.out_code), 64'h4000_0000 + 64'(i));
    end

    // Flush at count=2 with a same-cycle push.
    drive(1'b0, 1'b1, 32'h5000_0001, 32'h0000_6000, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 32'h5000_0002, 32'h0000_6004, 1'b0, 1'b1);
    cycle();
    check("flush_count", 64'(bus.count),     64'd0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b0, 1'b1, 32'h6000_0001, 32'h0000_7000, 1'b0, 1'b0);
    cycle();
    check("post_flush_head", 64'(bus.out_code), 64'h6000_0001);

    // Reset mid-stall with the queue full.
    drive(1'b0, 1'b1, 32'h6000_0002, 32'h0000_7004, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 32'h6000_0003, 32'h0000_7008, 1'b1, 1'b1);
    cycle();
    check("rst_full_count", 64'(bus.count), 64'd0);

`ifdef IFQ_STALL_CNT_EN
    drive(1'b0, 1'b1, 32'h7000_0001, 32'h0000_8000, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle();
    end
    check("stall_five", 64'(stall_cnt), 64'd5);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    check("stall_rst", 64'(stall_cnt), 64'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), $urandom, $urandom,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
      cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_outputs();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ifq.md
IFQ -- requirements
Module: ifq

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, meaning the number of queue entries; legal values are 2, 4 and 8.
REQ-002 SHALL define CW = log2(DEPTH)+1 as the width of the count port.
REQ-003 SHALL provide clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL provide reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL provide in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-006 SHALL provide in_code, input, 32 bits: the fetched instruction word.
REQ-007 SHALL provide in_pcc, input, 32 bits: the link address (PC+8) of the fetched instruction.
REQ-008 SHALL provide in_ready, output, 1 bit: the queue accepts a push this cycle.
REQ-009 SHALL provide out_valid, output, 1 bit: the head entry is valid for the decode stage.
REQ-010 SHALL provide out_code, output, 32 bits: the head instruction word.
REQ-011 SHALL provide out_pcc, output, 32 bits: the head link address.
REQ-012 SHALL provide out_ready, input, 1 bit: the decode stage consumes the head this cycle.
REQ-013 SHALL provide flush, input, 1 bit: discard all entries (taken branch, j, jal or jr redirect).
REQ-014 SHALL provide count, output, CW bits: the number of valid entries.

Function
REQ-015 SHALL perform a push on an edge where in_valid=1, in_ready=1 and flush=0; {in_code, in_pcc} is written at the tail and the tail pointer increments modulo DEPTH.
REQ-016 SHALL perform a pop on an edge where out_valid=1, out_ready=1 and flush=0; the head pointer increments modulo DEPTH.
REQ-017 SHALL be first-word-fall-through: out_code and out_pcc are driven combinationally from the head entry, so an entry pushed at edge k is visible on the outputs after edge k (one-cycle latency).
REQ-018 SHALL drive out_valid = (count != 0).
REQ-019 SHALL drive in_ready = (count < DEPTH), a function of registered state only, with no combinational path from out_ready.
REQ-020 SHALL drive out_code and out_pcc to 0 whenever out_valid = 0.
REQ-021 SHALL leave count unchanged on an edge with both a push and a pop, and SHALL write the new entry to the correct slot.
REQ-022 SHALL, when empty, perform no pop and no bypass: a pushed entry first appears on the next cycle.
REQ-023 SHALL, when full, ignore in_valid (no overwrite), while a pop on the same edge still completes.
REQ-024 SHALL give flush priority over push and pop: on a flush edge, count, head and tail all go to 0, and any same-cycle input is discarded.
REQ-025 SHALL hold entry contents stable while out_valid=1 and out_ready=0 (stall).
REQ-026 SHALL never let count exceed DEPTH or underflow below 0.

Reset
REQ-027 SHALL, on an edge with reset=1, set count=0, head=0 and tail=0, giving out_valid=0, in_ready=1, out_code=0 and out_pcc=0 after that edge.
REQ-028 SHALL give reset priority over flush, push and pop, including when reset is asserted mid-stall with the queue full.
REQ-029 SHALL NOT require entry storage to be reset; REQ-020 masks its contents.

Configuration
REQ-030 SHALL, when macro IFQ_STALL_CNT_EN is defined, add output stall_cnt (16 bits) that increments on every edge where out_valid=1 and out_ready=0 and flush=0, saturates at 16'hFFFF, and clears on reset only.
REQ-031 SHALL, when IFQ_STALL_CNT_EN is undefined, have neither the stall_cnt port nor its logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover reset: hold reset for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_code=0.
REQ-033 SHALL cover fill: push 0x2008_0001/0x3008 then 0x2009_0002/0x300C with out_ready=0 -> count=2, in_ready=0, out_code=0x2008_0001; a third push of 0x1000_0003 is ignored.
REQ-034 SHALL cover drain with wrap: push and pop simultaneously for 6 cycles at count=1 -> count stays 1, outputs appear in push order, and the pointers wrap with no lost or duplicate word.
REQ-035 SHALL cover flush: at count=2, assert flush with in_valid=1 -> next cycle count=0 and out_valid=0; the flushed and same-cycle words never appear at the output.
REQ-036 SHALL cover full pop-and-push: at count=2 with out_ready=1 and in_valid=1 -> a pop only; count=1 and the second entry becomes the head.
REQ-037 SHALL cover the stall counter with IFQ_STALL_CNT_EN defined: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; then reset -> stall_cnt=0.
